imem_dmem_arbiter: RTL
======================

Name: imem_dmem_arbiter

Overview:
- Shares one single-port, 1-cycle-latency unified SRAM between the core's instruction-fetch port and its data port.
- Both ports use the core's req/gnt/rvalid/err protocol.
- Data accesses have priority; a streak counter stops fetch starvation.
- Sits between CPU_EDABK_TOP and the memory macro, replacing the separate IMEM/DMEM hookup.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32, byte-address width on both requester ports.
- MEM_WORDS, 1024, SRAM depth in words. Valid byte addresses are 0 .. MEM_WORDS*4-1.
- MAX_DATA_STREAK, 4, maximum number of consecutive data grants while a fetch is pending.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_req_i  in  1  fetch request.
- instr_addr_i  in  ADDR_WIDTH  fetch byte address.
- instr_gnt_o  out  1  fetch accepted this cycle.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  DATA_WIDTH  fetched word.
- instr_err_o  out  1  fetch error; qualified by instr_rvalid_o.
- data_req_i  in  1  load/store request.
- data_we_i  in  1  1 = store.
- data_be_i  in  DATA_WIDTH/8  byte enables.
- data_addr_i  in  ADDR_WIDTH  data byte address.
- data_wdata_i  in  DATA_WIDTH  store data.
- data_gnt_o  out  1  data request accepted.
- data_rvalid_o  out  1  data response valid.
- data_rdata_o  out  DATA_WIDTH  load data.
- data_err_o  out  1  data error; qualified by data_rvalid_o.
- mem_en_o  out  1  SRAM access strobe.
- mem_we_o  out  1  SRAM write.
- mem_be_o  out  DATA_WIDTH/8  SRAM byte enables.
- mem_addr_o  out  clog2(MEM_WORDS)  SRAM word address.
- mem_wdata_o  out  DATA_WIDTH  SRAM write data.
- mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid one cycle after mem_en_o.

Behaviour:
- Reset (async assert): all outputs 0; state IDLE; data_streak=0. Any pending response is dropped and no rvalid is issued for it.
- Grant is combinational in the request cycle, at most one grant per cycle:
  - Data wins, unless instr_req_i=1 and data_streak==MAX_DATA_STREAK; then instr wins.
- data_streak update:
  - +1 (saturating) on each data grant while instr_req_i=1.
  - Cleared on any instr grant, or on any cycle where instr_req_i=0.
- Granted in-range access drives mem_en_o=1 in the same cycle:
  - mem_addr_o = addr[clog2(MEM_WORDS)+1:2].
  - Fetches force mem_we_o=0 and mem_be_o all-ones.
- Out-of-range address (addr >= MEM_WORDS*4):
  - Still granted, but mem_en_o=0.
  - err=1 with rvalid next cycle; rdata=0.
- Address bits [1:0] are ignored (the core issues aligned accesses only).
- Response latency is exactly 1 cycle after grant:
  - rvalid pulses for one cycle on the granted port.
  - Load and fetch rdata = mem_rdata_i; store rdata = 0.
- FSM states: IDLE, RESP_I, RESP_D.
  - Next state = RESP_I if instr granted, RESP_D if data granted, else IDLE. This applies from every state, so back-to-back grants are fully pipelined (one access per cycle).
  - The output register for rdata/err is captured per response; the non-responding port's rvalid stays 0.
- Requests held without grant must keep address and data stable; the arbiter does not check this.
- Simultaneous events:
  - Both ports request: data wins (streak permitting), instr sees gnt=0 and waits.
  - Response to one port and grant to the other in the same cycle is legal.
- Ungranted requests produce no memory activity.

Decomposition:
- Shared package holds:
  - arb_state_e {IDLE, RESP_I, RESP_D}.
  - owner_e {OWN_NONE, OWN_INSTR, OWN_DATA}.
  - Function for in-range address check.
  - Constant MEM_AW = clog2(MEM_WORDS).
- One natural sub-module, arb_streak_ctr: the saturating streak counter that outputs force_instr.

Test Plan:
- Single fetch: instr_req at 0x10, mem word 4 = 0x00500093 -> gnt same cycle, mem_addr_o=4, next cycle instr_rvalid=1 and rdata=0x00500093, err=0.
- Store then load: data store 0xDEADBEEF with be=4'b0011 to 0x20, then load 0x20 with old word 0x11223344 -> two back-to-back gnts, load rdata=0x1122BEEF, both rvalids 1 cycle after their gnt.
- Contention: both ports request continuously, MAX_DATA_STREAK=4 -> grant pattern D,D,D,D,I repeating; instr gnt on cycle 5; no cycle has two gnts.
- Out of range: data load at 0x1000 with MEM_WORDS=1024 -> gnt=1, mem_en_o=0, next cycle data_rvalid=1, data_err=1, rdata=0.
- Reset mid-op: assert rst in the cycle after a fetch gnt (response pending) -> instr_rvalid stays 0 immediately and all outputs are 0. After deassert, a new fetch completes normally.
- Idle/instr-only: instr_req held 10 cycles, data_req=0 -> 10 consecutive instr gnts, data_streak stays 0, rvalids pipelined 1 cycle behind.

Source files
------------

// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and helpers for the unified I/D memory arbiter.
// Holds FSM/owner enums and the SRAM address-range check.
package imem_dmem_arbiter_pkg;

  localparam int MEM_WORDS_DEF = 1024;
  localparam int MEM_AW = $clog2(MEM_WORDS_DEF);

  typedef enum logic [1:0] {
    IDLE,
    RESP_I,
    RESP_D
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INSTR,
    OWN_DATA
  } owner_e;

  function automatic logic addr_in_range(
    input logic [63:0] addr,
    input int unsigned words
  );
    return addr < ({32'd0, words} << 2);
  endfunction

endpackage

// File: rtl/imem_dmem_arbiter_streak_ctr.sv
// Saturating count of data grants taken while a fetch waits.
// Raises force_instr once the data streak limit is reached.
module arb_streak_ctr #(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic instr_req_i,
  input  logic instr_gnt_i,
  input  logic data_gnt_i,
  output logic force_instr_o
);

  localparam int CW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [CW-1:0] MAX_V = CW'(MAX_DATA_STREAK);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!instr_req_i || instr_gnt_i) begin
      r_cnt <= '0;
    end else if (data_gnt_i && (r_cnt != MAX_V)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign force_instr_o = instr_req_i && (r_cnt == MAX_V);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates fetch and data ports onto one 1-cycle SRAM.
// Data has priority; the streak counter bounds fetch starvation.
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MEM_WORDS       = MEM_WORDS_DEF,
  parameter int MAX_DATA_STREAK = 4,
  localparam int AW = $clog2(MEM_WORDS),
  localparam int BW = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  output logic                  instr_err_o,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [BW-1:0]         data_be_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [BW-1:0]         mem_be_o,
  output logic [AW-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  arb_state_e r_state, w_next;
  owner_e     w_own;
  logic       r_err, w_err_n;
  logic       r_pass, w_pass_n;
  logic       w_force, w_igrant, w_dgrant;
  logic       w_inr, w_mem_en, w_store;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_rdata;

  arb_streak_ctr #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_streak (
    .clk          (clk),
    .rst          (rst),
    .instr_req_i  (instr_req_i),
    .instr_gnt_i  (w_igrant),
    .data_gnt_i   (w_dgrant),
    .force_instr_o(w_force)
  );

  // Grants are masked during reset so every output reads 0.
  assign w_dgrant = !rst && data_req_i && !w_force;
  assign w_igrant = !rst && instr_req_i && !w_dgrant;

  always_comb begin
    w_own = OWN_NONE;
    if (w_dgrant) w_own = OWN_DATA;
    else if (w_igrant) w_own = OWN_INSTR;
  end

  assign w_addr   = (w_own == OWN_DATA) ? data_addr_i : instr_addr_i;
  assign w_inr    = addr_in_range(
                      {{(64-ADDR_WIDTH){1'b0}}, w_addr},
                      MEM_WORDS);
  assign w_store  = (w_own == OWN_DATA) && data_we_i;
  assign w_mem_en = (w_own != OWN_NONE) && w_inr;

  assign instr_gnt_o = w_igrant;
  assign data_gnt_o  = w_dgrant;
  assign mem_en_o    = w_mem_en;
  assign mem_we_o    = w_mem_en && w_store;
  assign mem_be_o    = !w_mem_en ? '0 :
                       (w_own == OWN_DATA) ? data_be_i : '1;
  assign mem_addr_o  = w_mem_en ? w_addr[AW+1:2] : '0;
  assign mem_wdata_o = mem_we_o ? data_wdata_i : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err_n;
      r_pass  <= w_pass_n;
    end
  end

  always_comb begin
    w_next         = IDLE;
    w_err_n        = 1'b0;
    w_pass_n       = 1'b0;
    instr_rvalid_o = 1'b0;
    data_rvalid_o  = 1'b0;
    unique case (w_own)
      OWN_INSTR: w_next = RESP_I;
      OWN_DATA:  w_next = RESP_D;
      default:   w_next = IDLE;
    endcase
    w_err_n  = (w_own != OWN_NONE) && !w_inr;
    w_pass_n = w_mem_en && !w_store;
    unique case (r_state)
      RESP_I:  instr_rvalid_o = 1'b1;
      RESP_D:  data_rvalid_o  = 1'b1;
      default: ;
    endcase
  end

  // Read data comes straight from the SRAM in the response cycle.
  assign w_rdata       = r_pass ? mem_rdata_i : '0;
  assign instr_rdata_o = instr_rvalid_o ? w_rdata : '0;
  assign data_rdata_o  = data_rvalid_o ? w_rdata : '0;
  assign instr_err_o   = instr_rvalid_o && r_err;
  assign data_err_o    = data_rvalid_o && r_err;

endmodule
